// File: rtl/cnn_pkg.sv
// cnn_pkg: shared state encoding and default widths for the CNN accelerator host-side blocks.
package cnn_pkg;
  typedef enum logic [2:0] {IDLE, ARM, LOAD, WAIT, DONE} feeder_state_e;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_RES_WIDTH  = 8;
  localparam int DEF_IMG_PIXELS = 1024;
endpackage

// File: rtl/cnn_image_feeder_wait_timer.sv
// feeder_wait_timer: loadable down-counter; tc is high while enabled and the count has run out.
module feeder_wait_timer #(
  parameter int COUNT = 200000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tc
);
  localparam int W = $clog2(COUNT + 1);
  logic [W-1:0] wait_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) wait_cnt <= '0;
    else if (load) wait_cnt <= W'(COUNT);
    else if (en && wait_cnt != '0) wait_cnt <= wait_cnt - W'(1);
  assign tc = en && (wait_cnt == '0);
endmodule

// File: rtl/cnn_image_feeder.sv
// cnn_image_feeder: streams one image into the accelerator input buffer, then captures its result.
// Optional FEEDER_CHECKSUM_EN adds a running modulo sum of accepted pixels on port checksum.
module cnn_image_feeder
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int IMG_PIXELS  = DEF_IMG_PIXELS,
  parameter int BASE_ADDR   = 0,
  parameter int RES_WIDTH   = DEF_RES_WIDTH,
  parameter int RESULT_WAIT = 200000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] sys_din,
  output logic [ADDR_WIDTH-1:0] sys_wr_addr,
  output logic                  sys_we,
  output logic                  sys_en,
  input  logic [RES_WIDTH-1:0]  sys_res,
  output logic [RES_WIDTH-1:0]  result,
  output logic                  result_valid
`ifdef FEEDER_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] checksum
`endif
);
  localparam int CW = $clog2(IMG_PIXELS + 1);
  feeder_state_e state, state_d;
  logic [CW-1:0] pix_cnt, pix_cnt_d;
  logic [DATA_WIDTH-1:0] sys_din_d;
  logic [ADDR_WIDTH-1:0] sys_wr_addr_d;
  logic [RES_WIDTH-1:0] result_d;
  logic busy_d, s_ready_d, sys_we_d, sys_en_d, result_valid_d;
  logic hs, tmr_load, tmr_tc;
  assign hs = s_valid && s_ready;
  feeder_wait_timer #(.COUNT(RESULT_WAIT)) u_timer (
    .clk (clk),
    .rst (rst),
    .load(tmr_load),
    .en  (state == WAIT),
    .tc  (tmr_tc)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state        <= IDLE;
      pix_cnt      <= '0;
      busy         <= 1'b0;
      s_ready      <= 1'b0;
      sys_din      <= '0;
      sys_wr_addr  <= '0;
      sys_we       <= 1'b0;
      sys_en       <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      state        <= state_d;
      pix_cnt      <= pix_cnt_d;
      busy         <= busy_d;
      s_ready      <= s_ready_d;
      sys_din      <= sys_din_d;
      sys_wr_addr  <= sys_wr_addr_d;
      sys_we       <= sys_we_d;
      sys_en       <= sys_en_d;
      result       <= result_d;
      result_valid <= result_valid_d;
    end
  // sys_we stays high across stalls: its falling edge is the accelerator's load-complete signal
  always_comb begin
    state_d        = state;
    pix_cnt_d      = pix_cnt;
    busy_d         = busy;
    s_ready_d      = s_ready;
    sys_din_d      = sys_din;
    sys_wr_addr_d  = sys_wr_addr;
    sys_we_d       = sys_we;
    sys_en_d       = sys_en;
    result_d       = result;
    result_valid_d = 1'b0;
    tmr_load       = 1'b0;
    case (state)
      IDLE:
        if (start) begin
          state_d   = ARM;
          busy_d    = 1'b1;
          sys_en_d  = 1'b1;
          pix_cnt_d = '0;
        end
      ARM: begin
        state_d   = LOAD;
        s_ready_d = 1'b1;
      end
      LOAD:
        if (hs) begin
          sys_we_d      = 1'b1;
          sys_din_d     = s_data;
          sys_wr_addr_d = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(pix_cnt);
          pix_cnt_d     = pix_cnt + CW'(1);
          if (pix_cnt == CW'(IMG_PIXELS - 1)) begin
            s_ready_d = 1'b0;
            state_d   = WAIT;
            tmr_load  = 1'b1;
          end
        end
      WAIT: begin
        sys_we_d = 1'b0;
        if (tmr_tc) begin
          result_d       = sys_res;
          result_valid_d = 1'b1;
          state_d        = DONE;
        end
      end
      DONE: begin
        sys_en_d = 1'b0;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
`ifdef FEEDER_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) checksum <= '0;
    else if (state == IDLE && start) checksum <= '0;
    else if (hs) checksum <= checksum + s_data;
`endif
endmodule

// File: tb/tb_cnn_image_feeder.sv
// tb_cnn_image_feeder: randomized image loads checked against a transaction-level model of the feeder.
module tb_cnn_image_feeder;
  localparam int N = 4;
  localparam int BASE = 16;
  localparam int RW = 5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic [7:0] sys_res = '0;
  logic busy, s_ready, sys_we, sys_en, result_valid;
  logic [15:0] sys_din;
  logic [31:0] sys_wr_addr;
  logic [7:0] result;
`ifdef FEEDER_CHECKSUM_EN
  logic [15:0] checksum;
`endif
  int checks = 0;
  int errors = 0;

  cnn_image_feeder #(
    .DATA_WIDTH(16), .ADDR_WIDTH(32), .IMG_PIXELS(N), .BASE_ADDR(BASE),
    .RES_WIDTH(8), .RESULT_WAIT(RW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .sys_din(sys_din), .sys_wr_addr(sys_wr_addr), .sys_we(sys_we), .sys_en(sys_en),
    .sys_res(sys_res), .result(result), .result_valid(result_valid)
`ifdef FEEDER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // bus observer: collapses the write stream into per-address hold counts and edge timestamps
  int img_id = 0, seen_id = 0, cyc = 0;
  int en_rise, en_fall, busy_fall, busy_rises, first_we, falls, fall_cyc, rv_cnt, rv_cyc, wbad, we_no_en;
  logic arm_ok;
  logic [31:0] fall_addr;
  logic [7:0] rv_val;
  int hold[N];
  logic [15:0] wdata[N];
  int hs_cyc[$];
  logic [15:0] hs_data[$];
  logic p_en = 1'b0, p_busy = 1'b0, p_we = 1'b0;

  always @(negedge clk) begin
    int a;
    cyc++;
    if (img_id != seen_id) begin
      seen_id = img_id;
      en_rise = -1; en_fall = -1; busy_fall = -1; busy_rises = 0; first_we = -1;
      falls = 0; fall_cyc = -1; rv_cnt = 0; rv_cyc = -1; wbad = 0; we_no_en = 0;
      arm_ok = 1'b0; fall_addr = '0; rv_val = '0;
      for (int i = 0; i < N; i++) begin
        hold[i] = 0;
        wdata[i] = '0;
      end
      hs_cyc.delete();
      hs_data.delete();
    end
    if (sys_en && !p_en) begin
      en_rise = cyc;
      arm_ok = !sys_we && !s_ready;
    end
    if (!sys_en && p_en) en_fall = cyc;
    if (busy && !p_busy) busy_rises++;
    if (!busy && p_busy) busy_fall = cyc;
    if (sys_we) begin
      if (first_we < 0) first_we = cyc;
      if (!sys_en) we_no_en++;
      a = int'(sys_wr_addr) - BASE;
      if (a >= 0 && a < N) begin
        hold[a]++;
        if (hold[a] == 1) wdata[a] = sys_din;
        else if (wdata[a] != sys_din) wbad++;
      end else wbad++;
    end
    if (!sys_we && p_we) begin
      falls++;
      fall_cyc = cyc;
      fall_addr = sys_wr_addr;
    end
    if (result_valid) begin
      rv_cnt++;
      rv_cyc = cyc;
      rv_val = result;
    end
    if (s_valid && s_ready) begin
      hs_cyc.push_back(cyc);
      hs_data.push_back(s_data);
    end
    p_en = sys_en;
    p_busy = busy;
    p_we = sys_we;
  end

  task automatic new_image();
    img_id++;
    tick();
    tick();
  endtask

  // mode 0: back-to-back, mode 1: 3-cycle stall after pixel 0, mode 2: random gaps and stray starts
  task automatic run_image(input int mode);
    logic [15:0] px[N];
    logic [15:0] sum;
    logic [7:0] res;
    logic hs;
    int idx, gap, t;
    sum = '0;
    for (int i = 0; i < N; i++) begin
      px[i] = (mode == 2) ? 16'($urandom) : 16'(17 * (i + 1));
      sum = sum + px[i];
    end
    res = (mode == 1) ? 8'h07 : 8'($urandom);
    sys_res = res;
    new_image();
    start = 1'b1;
    tick();
    start = 1'b0;
    idx = 0; gap = 0; t = 0;
    while (idx < N && t < 200) begin
      s_valid = (mode == 0) ? 1'b1 : (mode == 1) ? !(idx == 1 && gap < 3) : ($urandom_range(0, 2) != 0);
      s_data = s_valid ? px[idx] : 16'($urandom);
      start = (mode == 2) && ($urandom_range(0, 3) == 0);
      hs = s_valid && s_ready;
      tick();
      t++;
      if (hs) idx++;
      else if (idx == 1) gap++;
    end
    check("load_done", 64'(idx), 64'(N));
    t = 0;
    while (busy && t < 80) begin
      start = (mode == 2) && ($urandom_range(0, 3) == 0);
      s_valid = 1'b1;
      s_data = 16'($urandom);
      tick();
      t++;
    end
    check("busy_drop", 64'(busy), 64'(0));
    start = 1'b0;
    s_valid = 1'b0;
    tick();
    tick();
    check("arm_cycle", 64'(arm_ok), 64'(1));
    check("en_before_we", 64'(first_we > en_rise), 64'(1));
    check("we_without_en", 64'(we_no_en), 64'(0));
    check("busy_rises", 64'(busy_rises), 64'(1));
    check("accept_count", 64'(hs_cyc.size()), 64'(N));
    check("write_integrity", 64'(wbad), 64'(0));
    check("we_falls", 64'(falls), 64'(1));
    check("fall_addr", 64'(fall_addr), 64'(BASE + N - 1));
    if (hs_cyc.size() == N) begin
      check("first_write_latency", 64'(first_we), 64'(hs_cyc[0] + 1));
      for (int i = 0; i < N; i++) begin
        check($sformatf("accepted_%0d", i), 64'(hs_data[i]), 64'(px[i]));
        check($sformatf("wdata_%0d", i), 64'(wdata[i]), 64'(px[i]));
        check($sformatf("hold_%0d", i), 64'(hold[i]), 64'((i < N - 1) ? hs_cyc[i + 1] - hs_cyc[i] : 1));
      end
      check("fall_time", 64'(fall_cyc), 64'(hs_cyc[N - 1] + 2));
    end
    if (mode == 1) check("stall_hold_addr16", 64'(hold[0]), 64'(4));
    check("rv_pulses", 64'(rv_cnt), 64'(1));
    check("rv_delay", 64'(rv_cyc - fall_cyc), 64'(RW));
    check("rv_value", 64'(rv_val), 64'(res));
    check("en_fall", 64'(en_fall - rv_cyc), 64'(1));
    check("busy_fall", 64'(busy_fall - rv_cyc), 64'(1));
`ifdef FEEDER_CHECKSUM_EN
    check("checksum", 64'(checksum), 64'(sum));
    if (mode == 1) check("checksum_stall", 64'(checksum), 64'(16'h00AA));
`endif
    sys_res = ~res;
    tick();
    check("result_hold", 64'(result), 64'(res));
    check("idle_ready", 64'(s_ready), 64'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 64'({busy, s_ready, sys_we, sys_en, result_valid}), 64'(0));
    check({tag, "_din"}, 64'(sys_din), 64'(0));
    check({tag, "_addr"}, 64'(sys_wr_addr), 64'(0));
    check({tag, "_result"}, 64'(result), 64'(0));
  endtask

  initial begin
    int idx, t;
    #2;
    check_all_zero("reset");
    tick();
    tick();
    rst = 1'b0;
    s_valid = 1'b1;
    s_data = 16'h1234;
    tick();
    tick();
    check("idle_no_accept", 64'(s_ready), 64'(0));
    s_valid = 1'b0;
    run_image(0);
    run_image(1);
    for (int k = 0; k < 6; k++) run_image(2);
    // abort mid-load after two pixels; outputs clear without waiting for a clock
    new_image();
    start = 1'b1;
    tick();
    start = 1'b0;
    idx = 0; t = 0;
    s_valid = 1'b1;
    while (idx < 2 && t < 20) begin
      s_data = 16'($urandom);
      if (s_ready) idx++;
      tick();
      t++;
    end
    check("abort_pixels", 64'(idx), 64'(2));
    s_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("abort");
    tick();
    rst = 1'b0;
    tick();
    check("abort_stays_idle", 64'({busy, sys_we, sys_en}), 64'(0));
    run_image(0);
    run_image(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
